// File: rtl/qpsk_sample_packer_if.sv
// Byte-in / sample-out stream bundle for qpsk_sample_packer.
// The packer connects through the slave modport and its environment through the master modport.
interface qpsk_sample_packer_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output byte_in, byte_valid, sample_ready,
        input  sample_out, sample_valid
    );

    modport slave (
        input  byte_in, byte_valid, sample_ready,
        output sample_out, sample_valid
    );
endinterface

// File: rtl/qpsk_sample_packer.sv
// Packs demodulated byte pairs (low byte first) into 16-bit samples and buffers them in a small FIFO.
// Optional drop counter output is enabled by defining QPSK_PACKER_DROP_CNT_EN.
module qpsk_sample_packer #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    qpsk_sample_packer_if.slave  bus,
    input  logic                 align,
    input  logic                 clr_ovf,
    output logic [LVL_W-1:0]     fifo_level,
`ifdef QPSK_PACKER_DROP_CNT_EN
    output logic [15:0]          drop_count,
`endif
    output logic                 overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    phase_t             phase, phase_next;
    logic [7:0]         lo_reg;
    logic               lo_load;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               drop;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic [15:0]        mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH_LOW;
        end else begin
            phase <= phase_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        phase_next = phase;
        lo_load    = 1'b0;
        push       = 1'b0;
        if (align) begin
            // A byte arriving with align starts a fresh pair rather than completing one.
            lo_load    = bus.byte_valid;
            phase_next = bus.byte_valid ? PH_HIGH : PH_LOW;
        end else if (bus.byte_valid) begin
            case (phase)
                PH_LOW: begin
                    lo_load    = 1'b1;
                    phase_next = PH_HIGH;
                end
                PH_HIGH: begin
                    push       = 1'b1;
                    phase_next = PH_LOW;
                end
                default: phase_next = PH_LOW;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_reg <= '0;
        end else if (lo_load) begin
            lo_reg <= bus.byte_in;
        end
    end

    assign empty = (count == '0);
    assign full  = (count == LVL_W'(DEPTH));
    assign pop   = !empty && bus.sample_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // NOTE: sample storage has no reset; empty-gating of sample_out hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {bus.byte_in, lo_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef QPSK_PACKER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop) begin
            if (clr_ovf) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (clr_ovf) begin
            drop_count <= '0;
        end
    end
`endif

    assign bus.sample_out   = empty ? 16'h0000 : mem[rd_ptr];
    assign bus.sample_valid = !empty;
    assign fifo_level       = count;
endmodule

// File: tb/tb_qpsk_sample_packer.sv
// Self-checking bench for qpsk_sample_packer: directed scenarios plus random traffic,
// with expected samples queued by a pair-level model and consumed by a handshake monitor.
module tb_qpsk_sample_packer;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             align;
    logic             clr_ovf;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
`ifdef QPSK_PACKER_DROP_CNT_EN
    logic [15:0]      drop_count;
`endif

    qpsk_sample_packer_if bus ();

    qpsk_sample_packer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .align      (align),
        .clr_ovf    (clr_ovf),
        .fifo_level (fifo_level),
`ifdef QPSK_PACKER_DROP_CNT_EN
        .drop_count (drop_count),
`endif
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Reference model state: samples accepted but not yet consumed, a pending low byte, flags.
    logic [15:0] exp_q[$];
    bit          have_lo;
    logic [7:0]  lo_b;
    int          m_level;
    bit          m_ovf;
    int          m_drops;
    bit          mon_en;

    task automatic step(input bit rst, input bit bv, input logic [7:0] b,
                        input bit al, input bit rdy, input bit clr);
        bit          n_have;
        logic [7:0]  n_lo;
        int          n_level;
        bit          n_ovf;
        int          n_drops;
        bit          do_push;
        bit          do_pop;
        bit          drop;
        logic [15:0] smp;
        reset            = rst;
        bus.byte_valid   = bv;
        bus.byte_in      = b;
        align            = al;
        bus.sample_ready = rdy;
        clr_ovf          = clr;
        n_have  = have_lo;
        n_lo    = lo_b;
        n_ovf   = m_ovf;
        n_drops = m_drops;
        do_push = 1'b0;
        drop    = 1'b0;
        smp     = 16'h0;
        do_pop  = (m_level > 0) && rdy;
        if (al) begin
            n_have = bv;
            if (bv) n_lo = b;
        end else if (bv) begin
            if (!have_lo) begin
                n_have = 1'b1;
                n_lo   = b;
            end else begin
                smp    = {b, lo_b};
                n_have = 1'b0;
                if (m_level < DEPTH || do_pop) do_push = 1'b1;
                else                           drop    = 1'b1;
            end
        end
        n_level = m_level + int'(do_push) - int'(do_pop);
        if (drop) begin
            n_ovf   = 1'b1;
            n_drops = clr ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
        end else if (clr) begin
            n_ovf   = 1'b0;
            n_drops = 0;
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            have_lo = 1'b0;
            lo_b    = 8'h0;
            m_level = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            have_lo = n_have;
            lo_b    = n_lo;
            m_level = n_level;
            m_ovf   = n_ovf;
            m_drops = n_drops;
            if (do_push) exp_q.push_back(smp);
        end
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        step(1'b0, 1'b1, b, 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    task automatic send_sample(input logic [15:0] s, input bit rdy);
        send(s[7:0], rdy);
        send(s[15:8], rdy);
    endtask

    // Monitor: samples outputs mid-cycle, compares against the model, consumes on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("fifo_level", fifo_level, m_level);
                check("sample_valid", bus.sample_valid, m_level != 0);
                check("overflow", overflow, m_ovf);
`ifdef QPSK_PACKER_DROP_CNT_EN
                check("drop_count", drop_count, m_drops);
`endif
                if (!bus.sample_valid) begin
                    check("sample_out_idle", bus.sample_out, 0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_sample", bus.sample_out, -1);
                end else begin
                    check("sample_out", bus.sample_out, exp_q[0]);
                    if (bus.sample_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        mon_en = 1'b0;
        have_lo = 1'b0;
        lo_b = 8'h0;
        m_level = 0;
        m_ovf = 1'b0;
        m_drops = 0;
        reset = 1'b1;
        align = 1'b0;
        clr_ovf = 1'b0;
        bus.byte_in = 8'h0;
        bus.byte_valid = 1'b0;
        bus.sample_ready = 1'b0;

        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Basic pair with the sink always ready.
        send(8'h34, 1'b1);
        send(8'h12, 1'b1);
        idle(2, 1'b1);

        // Overfill with sink stalled, then drain.
        for (int i = 1; i <= 5; i++) send_sample(16'(i), 1'b0);
        idle(6, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Stray byte discarded by align.
        send(8'hAA, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        send(8'h78, 1'b1);
        send(8'h56, 1'b1);
        idle(2, 1'b1);

        // Align coincident with a byte makes that byte the low half.
        send(8'h11, 1'b1);
        step(1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        send(8'h33, 1'b1);
        idle(2, 1'b1);

        // Push into a full FIFO while the head is popped.
        for (int i = 0; i < 4; i++) send_sample(16'h1000 + 16'(i), 1'b0);
        send(8'hBC, 1'b0);
        send(8'h9A, 1'b1);
        idle(6, 1'b1);

        // Sign-bit pattern, then reset with two samples buffered and a low byte held.
        send_sample(16'h80FF, 1'b0);
        send_sample(16'h2211, 1'b0);
        send(8'h33, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h44, 1'b1);
        send(8'h55, 1'b1);
        idle(2, 1'b1);

        // Three drops, clear, then a drop coinciding with clear.
        for (int i = 0; i < 7; i++) send_sample(16'h2000 + 16'(i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send(8'h01, 1'b0);
        step(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 8'($urandom),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 29) == 0));
        end
        idle(8, 1'b1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
